dma_addr_gen: RTL and testbench
===============================

Name: dma_addr_gen

Overview:
- Ramsey-side DMA address generator, directly downstream of the SDMAC top level.
- Consumes _DMAEN, the bus-cycle strobes the SDMAC drives while bus master, and the slave terminations (_STERM/_DSACK/_BERR).
- Drives the 32-bit DMA address and advances it by the transferred byte count after each completed cycle.
- The start address is loaded through the ACR write strobe (register offset 0x0C).

Parameters:
- AW, 32, address counter width in bits.
- ALIGN_MASK, 2'b11, low ACR bits forced to zero on load (longword alignment).

Ports:
- SCLK  in  1  system clock (CPUCLKB); all logic on rising edge.
- RST  in  1  synchronous reset, active high.
- ACR_WR  in  1  one-cycle strobe: load ACR from ACR_D.
- ACR_D  in  AW  start address from the CPU data bus.
- _DMAEN  in  1  low = SDMAC owns the bus; address generation enabled.
- _AS  in  1  address strobe, already synchronous to SCLK.
- _STERM  in  1  synchronous 32-bit termination.
- _DSACK  in  2  asynchronous-port size acknowledge, already synchronised.
- _BERR  in  1  bus error.
- ADDR_O  out  AW  current DMA address.
- ADDR_OE  out  1  address bus drive enable.
- ACR_RB  out  AW  readback of the loaded start address.
- CYC_DONE  out  1  one-cycle pulse per completed transfer.
- BERR_FLAG  out  1  sticky bus-error indication.
- WRAP_FLAG  out  1  sticky flag: the counter wrapped past all-ones.
- LOAD_REJ  out  1  sticky flag: ACR_WR arrived while _DMAEN was low.

Behaviour:
- Reset (RST=1 at a clock edge):
  - ADDR_O=0, ACR_RB=0.
  - CYC_DONE=0, BERR_FLAG=0, WRAP_FLAG=0, LOAD_REJ=0, ADDR_OE=0.
  - State=IDLE.
  - Reset asserted mid-cycle aborts the cycle with no increment.
- State machine:
  - IDLE: _DMAEN=1. ACR_WR loads ADDR_O and ACR_RB with ACR_D & ~ALIGN_MASK (mask zero-extended to AW) on the next edge, and clears BERR_FLAG, WRAP_FLAG and LOAD_REJ. Go to ARMED when _DMAEN=0.
  - ARMED: ADDR_OE=1. Go to CYCLE on _AS sampled 1->0 (edge relative to the previous sample). Go to IDLE if _DMAEN=1.
  - CYCLE: wait for termination while _AS=0. Termination and increment are decoded in priority order:
    - _BERR=0: go to ERR; no increment.
    - _STERM=0: +4.
    - _DSACK=00: +4.
    - _DSACK=01: +2.
    - _DSACK=10: +1.
    - On a non-error termination, add the increment to ADDR_O at that edge (1-cycle latency), pulse CYC_DONE, then go to ACKWAIT.
    - _AS returning high without termination: abort to ARMED, no increment.
  - ACKWAIT: hold until _AS=1, then go to ARMED. Further terminations in this cycle are ignored, giving exactly one increment per bus cycle.
  - ERR: BERR_FLAG=1, ADDR_OE=0, ADDR_O held. Leave only when _DMAEN=1, to IDLE.
- If _DMAEN rises in any state, the state goes to IDLE and ADDR_OE=0 on the next edge. An increment due on that same edge is still applied.
- ACR_WR while _DMAEN=0: ignored, sets LOAD_REJ. ADDR_O and ACR_RB are unchanged.
- Arithmetic: modulo 2^AW. If the increment carries out of bit AW-1, set WRAP_FLAG; ADDR_O takes the wrapped value (e.g. FFFFFFFE+4 = 00000002).
- ADDR_OE is a registered output: 1 in ARMED, CYCLE and ACKWAIT only.

Decomposition:
- Shared package dma_pkg holds:
  - state enum {IDLE, ARMED, CYCLE, ACKWAIT, ERR};
  - increment constants INC_LONG=4, INC_WORD=2, INC_BYTE=1;
  - the ACR offset constant 0x0C.
- One natural sub-module, dma_term_decode: combinational priority decode of _BERR, _STERM and _DSACK into {term, err, inc[2:0]}.

Test Plan:
- Reset, then ACR_WR with ACR_D=0x00201003 -> ADDR_O=ACR_RB=0x00201000, all flags 0, ADDR_OE=0.
- Lower _DMAEN, then run three _AS cycles terminated by _STERM, _DSACK=01 and _DSACK=10 -> ADDR_O steps 0x00201004, 0x00201006, 0x00201007, with one CYC_DONE pulse each.
- Hold _DSACK=00 for 4 clocks within one _AS-low cycle -> exactly one +4. Then an _AS cycle with no termination -> no change.
- Load 0xFFFFFFFC, then a _STERM cycle -> ADDR_O=0x00000000, WRAP_FLAG=1.
- _BERR=0 during CYCLE -> BERR_FLAG=1, ADDR_OE=0, address held. Raise _DMAEN -> IDLE; the next ACR_WR clears BERR_FLAG.
- ACR_WR with _DMAEN=0 -> LOAD_REJ=1, ADDR_O unchanged. RST asserted mid-CYCLE -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the Ramsey-side DMA address generator.
//   state_e        : address generator state machine encoding
//   INC_*          : byte increments per termination size
//   ACR_OFFSET     : register offset of the address counter register
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CYCLE,
    ACKWAIT,
    ERR
  } state_e;

  localparam logic [2:0] INC_LONG = 3'd4;
  localparam logic [2:0] INC_WORD = 3'd2;
  localparam logic [2:0] INC_BYTE = 3'd1;

  localparam logic [7:0] ACR_OFFSET = 8'h0C;

  // Address bus is driven while the generator owns an active or pending cycle.
  function automatic logic drives_bus(state_e s);
    return (s == ARMED) || (s == CYCLE) || (s == ACKWAIT);
  endfunction

endpackage

// File: rtl/dma_term_decode.sv
// Combinational priority decode of the slave bus-cycle terminations.
//   berr_n_i  : _BERR, bus error (highest priority)
//   sterm_n_i : _STERM, synchronous 32-bit termination
//   dsack_n_i : _DSACK[1:0], asynchronous-port size acknowledge
//   term_o    : a non-error termination is present
//   err_o     : bus error termination is present
//   inc_o     : byte increment for the terminated transfer (0 if none)
module dma_term_decode
  import dma_pkg::*;
(
  input  logic       berr_n_i,
  input  logic       sterm_n_i,
  input  logic [1:0] dsack_n_i,
  output logic       term_o,
  output logic       err_o,
  output logic [2:0] inc_o
);

  always_comb begin
    term_o = 1'b0;
    err_o  = 1'b0;
    inc_o  = '0;
    if (!berr_n_i) begin
      err_o = 1'b1;
    end else if (!sterm_n_i) begin
      term_o = 1'b1;
      inc_o  = INC_LONG;
    end else begin
      unique case (dsack_n_i)
        2'b00: begin term_o = 1'b1; inc_o = INC_LONG; end
        2'b01: begin term_o = 1'b1; inc_o = INC_WORD; end
        2'b10: begin term_o = 1'b1; inc_o = INC_BYTE; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_addr_gen.sv
// DMA address generator: holds the DMA address counter, loads it from the
// ACR write strobe and advances it by the transferred byte count once per
// completed bus cycle while the SDMAC owns the bus.
//   SCLK      : system clock, rising edge
//   RST       : synchronous reset, active high
//   ACR_WR    : one-cycle ACR load strobe, ACR_D : start address
//   _DMAEN    : low = SDMAC owns the bus
//   _AS       : address strobe (synchronous)
//   _STERM, _DSACK, _BERR : slave terminations
//   ADDR_O    : current DMA address, ADDR_OE : address drive enable
//   ACR_RB    : readback of loaded start address
//   CYC_DONE  : one-cycle pulse per completed transfer
//   BERR_FLAG, WRAP_FLAG, LOAD_REJ : sticky status flags
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter logic [1:0]  ALIGN_MASK = 2'b11
) (
  input  logic          SCLK,
  input  logic          RST,
  input  logic          ACR_WR,
  input  logic [AW-1:0] ACR_D,
  input  logic          _DMAEN,
  input  logic          _AS,
  input  logic          _STERM,
  input  logic [1:0]    _DSACK,
  input  logic          _BERR,
  output logic [AW-1:0] ADDR_O,
  output logic          ADDR_OE,
  output logic [AW-1:0] ACR_RB,
  output logic          CYC_DONE,
  output logic          BERR_FLAG,
  output logic          WRAP_FLAG,
  output logic          LOAD_REJ
);

  state_e        state_q, state_d;
  logic          as_prev_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] acr_q, acr_d;
  logic          oe_q, oe_d;
  logic          done_q, done_d;
  logic          berr_q, berr_d;
  logic          wrap_q, wrap_d;
  logic          rej_q, rej_d;

  logic          term, err;
  logic [2:0]    inc;
  logic          as_fall, in_cycle, do_inc, do_err, load_ok, load_rej;
  logic [AW:0]   sum;
  logic [AW-1:0] align_ext;

  dma_term_decode u_term (
    .berr_n_i  (_BERR),
    .sterm_n_i (_STERM),
    .dsack_n_i (_DSACK),
    .term_o    (term),
    .err_o     (err),
    .inc_o     (inc)
  );

  assign align_ext = {{(AW-2){1'b0}}, ALIGN_MASK};
  assign as_fall   = as_prev_q & ~_AS;
  assign in_cycle  = (state_q == CYCLE) && !_AS;
  // Increment is taken even when _DMAEN rises on the same edge.
  assign do_inc    = in_cycle && term;
  assign do_err    = in_cycle && err;
  assign load_ok   = ACR_WR && _DMAEN && (state_q == IDLE);
  assign load_rej  = ACR_WR && !_DMAEN;
  // One extra bit captures the carry out of the top address bit.
  assign sum       = {1'b0, addr_q} + {{(AW-2){1'b0}}, inc};

  // State register
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q   <= IDLE;
      as_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      as_prev_q <= _AS;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (_DMAEN) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (as_fall) state_d = CYCLE;
        CYCLE: begin
          if (_AS)       state_d = ARMED;
          else if (err)  state_d = ERR;
          else if (term) state_d = ACKWAIT;
        end
        ACKWAIT: if (_AS) state_d = ARMED;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    oe_d   = drives_bus(state_d);
    addr_d = addr_q;
    acr_d  = acr_q;
    done_d = 1'b0;
    berr_d = berr_q;
    wrap_d = wrap_q;
    rej_d  = rej_q;
    if (load_ok) begin
      addr_d = ACR_D & ~align_ext;
      acr_d  = ACR_D & ~align_ext;
      berr_d = 1'b0;
      wrap_d = 1'b0;
      rej_d  = 1'b0;
    end
    if (load_rej) rej_d = 1'b1;
    if (do_inc) begin
      addr_d = sum[AW-1:0];
      done_d = 1'b1;
      if (sum[AW]) wrap_d = 1'b1;
    end
    if (do_err) berr_d = 1'b1;
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      addr_q <= '0;
      acr_q  <= '0;
      oe_q   <= 1'b0;
      done_q <= 1'b0;
      berr_q <= 1'b0;
      wrap_q <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      acr_q  <= acr_d;
      oe_q   <= oe_d;
      done_q <= done_d;
      berr_q <= berr_d;
      wrap_q <= wrap_d;
      rej_q  <= rej_d;
    end
  end

  assign ADDR_O    = addr_q;
  assign ACR_RB    = acr_q;
  assign ADDR_OE   = oe_q;
  assign CYC_DONE  = done_q;
  assign BERR_FLAG = berr_q;
  assign WRAP_FLAG = wrap_q;
  assign LOAD_REJ  = rej_q;

endmodule

// File: tb/tb_dma_addr_gen.sv
// Self-checking bench for dma_addr_gen. Expected values come from a
// bus-cycle-level model: address += size per completed cycle, modulo 2^32.
module tb_dma_addr_gen;

  logic        SCLK;
  logic        RST;
  logic        ACR_WR;
  logic [31:0] ACR_D;
  logic        _DMAEN;
  logic        _AS;
  logic        _STERM;
  logic [1:0]  _DSACK;
  logic        _BERR;
  logic [31:0] ADDR_O;
  logic        ADDR_OE;
  logic [31:0] ACR_RB;
  logic        CYC_DONE;
  logic        BERR_FLAG;
  logic        WRAP_FLAG;
  logic        LOAD_REJ;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen;

  // Reference model state
  logic [31:0] m_addr, m_acr;
  logic        m_berr, m_wrap, m_rej;

  localparam int K_STERM = 0, K_DS00 = 1, K_DS01 = 2, K_DS10 = 3, K_NONE = 4, K_BERR = 5;

  dma_addr_gen #(.AW(32), .ALIGN_MASK(2'b11)) dut (
    .SCLK      (SCLK),
    .RST       (RST),
    .ACR_WR    (ACR_WR),
    .ACR_D     (ACR_D),
    ._DMAEN    (_DMAEN),
    ._AS       (_AS),
    ._STERM    (_STERM),
    ._DSACK    (_DSACK),
    ._BERR     (_BERR),
    .ADDR_O    (ADDR_O),
    .ADDR_OE   (ADDR_OE),
    .ACR_RB    (ACR_RB),
    .CYC_DONE  (CYC_DONE),
    .BERR_FLAG (BERR_FLAG),
    .WRAP_FLAG (WRAP_FLAG),
    .LOAD_REJ  (LOAD_REJ)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic step();
    @(posedge SCLK);
    #1;
    if (CYC_DONE === 1'b1) done_seen++;
  endtask

  function automatic int inc_of(int kind);
    case (kind)
      K_STERM, K_DS00: return 4;
      K_DS01:          return 2;
      K_DS10:          return 1;
      default:         return 0;
    endcase
  endfunction

  function automatic void model_cycle(int kind);
    logic [32:0] s;
    s = {1'b0, m_addr} + 33'(inc_of(kind));
    m_addr = s[31:0];
    if (s[32]) m_wrap = 1'b1;
    if (kind == K_BERR) m_berr = 1'b1;
  endfunction

  task automatic release_term();
    _STERM = 1'b1; _DSACK = 2'b11; _BERR = 1'b1;
  endtask

  task automatic set_term(int kind);
    case (kind)
      K_STERM: _STERM = 1'b0;
      K_DS00:  _DSACK = 2'b00;
      K_DS01:  _DSACK = 2'b01;
      K_DS10:  _DSACK = 2'b10;
      K_BERR:  _BERR  = 1'b0;
      default: ;
    endcase
  endtask

  // One bus cycle from ARMED: termination held for 'hold' clocks.
  task automatic bus_cycle(int kind, int hold);
    done_seen = 0;
    _AS = 1'b0;
    step();
    if (kind == K_NONE) begin
      step(); step();
    end else begin
      set_term(kind);
      repeat (hold) step();
    end
    release_term();
    _AS = 1'b1;
    step();
    model_cycle(kind);
  endtask

  task automatic load(logic [31:0] d);
    ACR_D = d; ACR_WR = 1'b1;
    step();
    ACR_WR = 1'b0;
    m_addr = d & ~32'h3; m_acr = d & ~32'h3;
    m_berr = 1'b0; m_wrap = 1'b0; m_rej = 1'b0;
  endtask

  task automatic arm();    _DMAEN = 1'b0; step(); endtask
  task automatic disarm(); _DMAEN = 1'b1; step(); endtask

  task automatic test_reset();
    RST = 1'b1; ACR_WR = 1'b0; ACR_D = '0; _DMAEN = 1'b1; _AS = 1'b1;
    release_term();
    step(); step();
    RST = 1'b0;
    m_addr = '0; m_acr = '0; m_berr = 0; m_wrap = 0; m_rej = 0;
    n_checks++;
    if ({ADDR_O, ACR_RB, ADDR_OE, CYC_DONE, BERR_FLAG, WRAP_FLAG, LOAD_REJ} !== '0) begin
      n_fail++;
      $display("FAIL reset: got addr=%h acr=%h oe=%b done=%b berr=%b wrap=%b rej=%b, expected all zero",
               ADDR_O, ACR_RB, ADDR_OE, CYC_DONE, BERR_FLAG, WRAP_FLAG, LOAD_REJ);
    end
  endtask

  task automatic test_load();
    load(32'h0020_1003);
    n_checks++;
    if (ADDR_O !== 32'h0020_1000 || ACR_RB !== 32'h0020_1000) begin
      n_fail++; $display("FAIL load: got addr=%h acr=%h, expected 00201000", ADDR_O, ACR_RB);
    end
    n_checks++;
    if ({ADDR_OE, BERR_FLAG, WRAP_FLAG, LOAD_REJ} !== 4'b0000) begin
      n_fail++; $display("FAIL load_flags: got %b, expected 0000", {ADDR_OE, BERR_FLAG, WRAP_FLAG, LOAD_REJ});
    end
  endtask

  task automatic test_sizes();
    logic [31:0] exp_tab [3];
    int          kinds   [3];
    exp_tab = '{32'h0020_1004, 32'h0020_1006, 32'h0020_1007};
    kinds   = '{K_STERM, K_DS01, K_DS10};
    arm();
    n_checks++;
    if (ADDR_OE !== 1'b1) begin n_fail++; $display("FAIL armed_oe: got %b, expected 1", ADDR_OE); end
    for (int i = 0; i < 3; i++) begin
      bus_cycle(kinds[i], 1);
      n_checks++;
      if (ADDR_O !== exp_tab[i] || done_seen != 1) begin
        n_fail++;
        $display("FAIL size%0d: got addr=%h pulses=%0d, expected addr=%h pulses=1", i, ADDR_O, done_seen, exp_tab[i]);
      end
    end
  endtask

  task automatic test_hold_and_abort();
    bus_cycle(K_DS00, 4);
    n_checks++;
    if (ADDR_O !== m_addr || ADDR_O !== 32'h0020_100B || done_seen != 1) begin
      n_fail++; $display("FAIL hold4: got addr=%h pulses=%0d, expected addr=%h pulses=1", ADDR_O, done_seen, m_addr);
    end
    bus_cycle(K_NONE, 1);
    n_checks++;
    if (ADDR_O !== m_addr || done_seen != 0 || ADDR_OE !== 1'b1) begin
      n_fail++; $display("FAIL abort: got addr=%h pulses=%0d oe=%b, expected addr=%h pulses=0 oe=1", ADDR_O, done_seen, ADDR_OE, m_addr);
    end
  endtask

  task automatic test_wrap();
    disarm();
    load(32'hFFFF_FFFC);
    arm();
    bus_cycle(K_STERM, 1);
    n_checks++;
    if (ADDR_O !== 32'h0 || WRAP_FLAG !== 1'b1) begin
      n_fail++; $display("FAIL wrap: got addr=%h wrap=%b, expected 00000000 wrap=1", ADDR_O, WRAP_FLAG);
    end
  endtask

  task automatic test_berr();
    disarm();
    load(32'h0000_4000);
    arm();
    bus_cycle(K_BERR, 1);
    n_checks++;
    if (BERR_FLAG !== 1'b1 || ADDR_OE !== 1'b0 || ADDR_O !== 32'h0000_4000 || done_seen != 0) begin
      n_fail++; $display("FAIL berr: got berr=%b oe=%b addr=%h pulses=%0d, expected 1 0 00004000 0", BERR_FLAG, ADDR_OE, ADDR_O, done_seen);
    end
    disarm();
    n_checks++;
    if (ADDR_OE !== 1'b0 || BERR_FLAG !== 1'b1) begin
      n_fail++; $display("FAIL berr_idle: got oe=%b berr=%b, expected 0 1", ADDR_OE, BERR_FLAG);
    end
    load(32'h0000_5000);
    n_checks++;
    if (BERR_FLAG !== 1'b0 || ADDR_O !== 32'h0000_5000) begin
      n_fail++; $display("FAIL berr_clear: got berr=%b addr=%h, expected 0 00005000", BERR_FLAG, ADDR_O);
    end
  endtask

  task automatic test_load_reject();
    arm();
    ACR_D = 32'hDEAD_BEEF; ACR_WR = 1'b1;
    step();
    ACR_WR = 1'b0;
    m_rej = 1'b1;
    n_checks++;
    if (LOAD_REJ !== 1'b1 || ADDR_O !== m_addr || ACR_RB !== m_acr) begin
      n_fail++; $display("FAIL load_rej: got rej=%b addr=%h acr=%h, expected 1 %h %h", LOAD_REJ, ADDR_O, ACR_RB, m_addr, m_acr);
    end
  endtask

  // _DMAEN rises on the same edge as a termination: increment still taken.
  task automatic test_dmaen_drop();
    done_seen = 0;
    _AS = 1'b0;
    step();
    _STERM = 1'b0; _DMAEN = 1'b1;
    step();
    model_cycle(K_STERM);
    n_checks++;
    if (ADDR_O !== m_addr || ADDR_OE !== 1'b0 || done_seen != 1) begin
      n_fail++; $display("FAIL dmaen_drop: got addr=%h oe=%b pulses=%0d, expected %h 0 1", ADDR_O, ADDR_OE, done_seen, m_addr);
    end
    release_term(); _AS = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      logic [31:0] base;
      base = $urandom;
      if (r % 3 == 0) base = 32'hFFFF_FFE0 | (base & 32'h1F);
      disarm();
      load(base);
      arm();
      for (int c = 0; c < 8; c++) begin
        int kind, hold, exp_pulses;
        kind = $urandom_range(0, 4);
        hold = $urandom_range(1, 3);
        exp_pulses = (kind == K_NONE) ? 0 : 1;
        bus_cycle(kind, hold);
        n_checks++;
        if (ADDR_O !== m_addr || WRAP_FLAG !== m_wrap || done_seen != exp_pulses) begin
          n_fail++;
          $display("FAIL random r%0d c%0d kind%0d: got addr=%h wrap=%b pulses=%0d, expected %h %b %0d",
                   r, c, kind, ADDR_O, WRAP_FLAG, done_seen, m_addr, m_wrap, exp_pulses);
        end
      end
    end
  endtask

  task automatic test_reset_mid_cycle();
    _AS = 1'b0;
    step();
    _DSACK = 2'b00; RST = 1'b1;
    step();
    n_checks++;
    if ({ADDR_O, ACR_RB, ADDR_OE, CYC_DONE, BERR_FLAG, WRAP_FLAG, LOAD_REJ} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got addr=%h acr=%h oe=%b done=%b berr=%b wrap=%b rej=%b, expected all zero",
               ADDR_O, ACR_RB, ADDR_OE, CYC_DONE, BERR_FLAG, WRAP_FLAG, LOAD_REJ);
    end
    RST = 1'b0; release_term(); _AS = 1'b1; _DMAEN = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_sizes();
    test_hold_and_abort();
    test_wrap();
    test_berr();
    test_load_reject();
    test_dmaen_drop();
    test_random();
    arm();
    test_reset_mid_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
